// File: rtl/reg_lib_pkg.sv
// rtl/reg_lib_pkg.sv - shared state encoding and counter-width helper for the register library
//
// Contents:
//   state_e   : transmit sequencer states (2'd3 is unused and recovers to IDLE)
//   cnt_width : counter width for a modulus n, never narrower than one bit
package reg_lib_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // max(1, clog2(n)) so that a modulus of 1 still gets a legal 1-bit counter
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_reg_en.sv
// rtl/shift_reg_en.sv - N-bit right-shift register with parallel load, shift enable and clear
//
// Ports:
//   clk       in  1  rising-edge clock
//   rst       in  1  asynchronous active-high reset (register to 0)
//   clr       in  1  synchronous clear, highest priority
//   load      in  1  parallel load of load_data
//   shift     in  1  shift right by one, zero fill at the MSB
//   load_data in  N  parallel load value
//   q         out N  register contents
// With none of clr/load/shift asserted the register holds its value.
module shift_reg_en #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] load_data,
    output logic [N-1:0] q
);

    logic [N-1:0] q_d;
    logic [N-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = load_data;
        end else if (shift) begin
            q_d = {1'b0, q_q[N-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/piso_tx_sequencer.sv
// rtl/piso_tx_sequencer.sv - parallel-in/serial-out transmit sequencer with hold divider and abort
//
// Parameters:
//   N   word width in bits (N >= 2)
//   DIV clock cycles each serial bit is held (DIV >= 1)
// Ports:
//   clk      in  1  rising-edge clock
//   reset    in  1  asynchronous active-high reset
//   in_valid in  1  word offered on in_data
//   in_ready out 1  sequencer can accept a word (IDLE only)
//   in_data  in  N  word to transmit, sampled on the handshake cycle
//   abort    in  1  synchronous abort, honoured only while shifting
//   so       out 1  serial data, LSB first, 0 when not shifting
//   so_valid out 1  so carries a frame bit
//   busy     out 1  frame in progress (SHIFT and DONE)
//   done     out 1  one-cycle pulse after the last bit period
module piso_tx_sequencer
    import reg_lib_pkg::*;
#(
    parameter int N   = 4,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         abort,
    output logic         so,
    output logic         so_valid,
    output logic         busy,
    output logic         done
);

    localparam int BW = cnt_width(N);
    localparam int DW = cnt_width(DIV);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    state_e          state_d;
    state_e          state_q;
    logic [BW-1:0]   bit_cnt_d;
    logic [BW-1:0]   bit_cnt_q;
    logic [DW-1:0]   div_cnt_d;
    logic [DW-1:0]   div_cnt_q;
    logic            sreg_clr;
    logic            sreg_load;
    logic            sreg_shift;
    logic            bit_end;
    logic [N-1:0]    sreg;

    shift_reg_en #(
        .N(N)
    ) u_sreg (
        .clk       (clk),
        .rst       (reset),
        .clr       (sreg_clr),
        .load      (sreg_load),
        .shift     (sreg_shift),
        .load_data (in_data),
        .q         (sreg)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        sreg_clr   = 1'b0;
        sreg_load  = 1'b0;
        sreg_shift = 1'b0;
        // With DIV=1 DIV_LAST is 0 and div_cnt never leaves 0, so every
        // SHIFT cycle is a bit boundary.
        bit_end    = (div_cnt_q == DIV_LAST);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d   = ST_SHIFT;
                    sreg_load = 1'b1;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                // abort takes priority over a last-bit wrap in the same cycle
                if (abort) begin
                    state_d   = ST_IDLE;
                    sreg_clr  = 1'b1;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end else if (bit_end) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        sreg_shift = 1'b1;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                sreg_clr  = 1'b1;
                bit_cnt_d = '0;
                div_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    // All outputs are decodes of registered state and register contents only.
    assign in_ready = (state_q == ST_IDLE);
    assign so_valid = (state_q == ST_SHIFT);
    assign so       = (state_q == ST_SHIFT) && sreg[0];
    assign busy     = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_piso_tx_sequencer.sv
// tb/tb_piso_tx_sequencer.sv - randomized self-checking bench for piso_tx_sequencer over four configurations
module tb_piso_tx_sequencer;

    localparam int L = 4;
    localparam int LN [L] = '{4, 4, 4, 8};
    localparam int LD [L] = '{1, 3, 2, 1};

    logic           clk = 1'b0;
    logic           reset;
    logic [L-1:0]   in_valid;
    logic [L-1:0]   abort;
    logic [7:0]     in_data [L];
    logic           in_ready [L];
    logic           so [L];
    logic           so_valid [L];
    logic           busy [L];
    logic           done [L];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model: per lane, whether a frame exists, its accept cycle and word
    bit         act [L];
    int         kc [L];
    logic [7:0] word [L];
    int         last_acc [L];
    int         prev_acc [L];

    always #5 clk = ~clk;

    piso_tx_sequencer #(.N(4), .DIV(1)) u_d0 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0][3:0]), .abort(abort[0]), .so(so[0]), .so_valid(so_valid[0]),
        .busy(busy[0]), .done(done[0]));
    piso_tx_sequencer #(.N(4), .DIV(3)) u_d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1][3:0]), .abort(abort[1]), .so(so[1]), .so_valid(so_valid[1]),
        .busy(busy[1]), .done(done[1]));
    piso_tx_sequencer #(.N(4), .DIV(2)) u_d2 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2][3:0]), .abort(abort[2]), .so(so[2]), .so_valid(so_valid[2]),
        .busy(busy[2]), .done(done[2]));
    piso_tx_sequencer #(.N(8), .DIV(1)) u_d3 (
        .clk(clk), .reset(reset), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_data(in_data[3]), .abort(abort[3]), .so(so[3]), .so_valid(so_valid[3]),
        .busy(busy[3]), .done(done[3]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // 0 idle, 1 shifting, 2 done pulse, for the period following edge c
    function automatic int phase(input int l, input int c);
        int s;
        int nd;
        nd = LN[l] * LD[l];
        if (!act[l]) return 0;
        s = c - kc[l];
        if (s < nd) return 1;
        if (s == nd) return 2;
        return 0;
    endfunction

    // expected {in_ready, so, so_valid, busy, done} for the current period
    function automatic logic [4:0] expect_out(input int l);
        int ph;
        int s;
        ph = phase(l, cyc);
        s  = cyc - kc[l];
        if (ph == 1) return {1'b0, word[l][s / LD[l]], 3'b110};
        if (ph == 2) return 5'b00011;
        return 5'b10000;
    endfunction

    task automatic model_edge();
        int ph;
        for (int l = 0; l < L; l++) begin
            if (reset) begin
                act[l] = 1'b0;
            end else begin
                ph = phase(l, cyc - 1);
                if (ph == 0 && in_valid[l]) begin
                    act[l]      = 1'b1;
                    kc[l]       = cyc;
                    word[l]     = in_data[l];
                    prev_acc[l] = last_acc[l];
                    last_acc[l] = cyc;
                end else if (ph == 1 && abort[l]) begin
                    act[l] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int l = 0; l < L; l++) begin
            check_eq($sformatf("lane%0d outputs", l),
                     {27'd0, in_ready[l], so[l], so_valid[l], busy[l], done[l]},
                     {27'd0, expect_out(l)});
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #2;
        check_all();
    endtask

    task automatic send(input int l, input logic [7:0] d);
        in_valid[l] = 1'b1;
        in_data[l]  = d;
        step();
        in_valid[l] = 1'b0;
        check_eq($sformatf("lane%0d accepted", l), 32'(last_acc[l] == cyc), 32'd1);
    endtask

    task automatic frame_cap(input int l, input logic [7:0] d, output logic [15:0] cap);
        int nd;
        nd  = LN[l] * LD[l];
        cap = '0;
        send(l, d);
        for (int i = 0; i < nd; i++) begin
            cap[i] = so[l];
            step();
        end
        check_eq($sformatf("lane%0d done after frame", l), 32'(done[l]), 32'd1);
        step();
        check_eq($sformatf("lane%0d ready after done", l), 32'(in_ready[l]), 32'd1);
    endtask

    logic [15:0] cap;
    int          first_acc;
    bit          got_b;

    initial begin
        reset    = 1'b1;
        in_valid = '0;
        abort    = '0;
        for (int l = 0; l < L; l++) begin
            in_data[l]  = '0;
            act[l]      = 1'b0;
            kc[l]       = 0;
            word[l]     = '0;
            last_acc[l] = -100;
            prev_acc[l] = -100;
        end
        repeat (3) step();
        #3 reset = 1'b0;
        repeat (2) step();

        // N=4 DIV=1, 1011
        frame_cap(0, 8'h0B, cap);
        check_eq("lane0 stream 1011", 32'(cap[3:0]), 32'h0000000B);

        // N=4 DIV=3, 0110 held 3 cycles per bit
        frame_cap(1, 8'h06, cap);
        check_eq("lane1 stream 0110x3", 32'(cap[11:0]), 32'h000001F8);

        // in_valid held with A then B
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h09;
        step();
        first_acc   = last_acc[0];
        check_eq("lane0 A accepted", 32'(first_acc == cyc), 32'd1);
        in_data[0]  = 8'h06;
        got_b       = 1'b0;
        for (int i = 0; i < 20 && !got_b; i++) begin
            step();
            if (last_acc[0] != first_acc) got_b = 1'b1;
        end
        in_valid[0] = 1'b0;
        check_eq("lane0 B accepted", 32'(got_b), 32'd1);
        check_eq("lane0 A-B spacing", 32'(last_acc[0] - prev_acc[0]), 32'd6);
        repeat (8) step();

        // abort on the final bit boundary, N=4 DIV=2
        send(2, 8'h0F);
        repeat (7) step();
        abort[2] = 1'b1;
        step();
        abort[2] = 1'b0;
        check_eq("lane2 ready after abort", 32'(in_ready[2]), 32'd1);
        check_eq("lane2 no done after abort", 32'(done[2]), 32'd0);
        repeat (3) step();
        frame_cap(2, 8'h0A, cap);
        check_eq("lane2 stream after abort", 32'(cap[7:0]), 32'h000000CC);

        // asynchronous reset between edges mid-frame
        send(3, 8'hA5);
        repeat (3) step();
        #3 reset = 1'b1;
        #1;
        for (int l = 0; l < L; l++) act[l] = 1'b0;
        check_all();
        check_eq("lane3 async reset so_valid", 32'(so_valid[3]), 32'd0);
        check_eq("lane3 async reset in_ready", 32'(in_ready[3]), 32'd1);
        repeat (2) step();
        #3 reset = 1'b0;
        step();

        // N=8 DIV=1, A5
        frame_cap(3, 8'hA5, cap);
        check_eq("lane3 stream A5", 32'(cap[7:0]), 32'h000000A5);

        // randomized traffic on all lanes
        for (int i = 0; i < 400; i++) begin
            for (int l = 0; l < L; l++) begin
                in_valid[l] = ($urandom_range(0, 3) != 0);
                in_data[l]  = 8'($urandom);
                abort[l]    = ($urandom_range(0, 15) == 0);
            end
            step();
        end
        in_valid = '0;
        abort    = '0;
        repeat (30) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
